// File: rtl/ir_bin_multiplier_pkg.sv
// Shared types and constants for the IR bin multiplier stage.
// Holds the complex sample type and the round-half-up saturating narrowing helper.
package ir_pkg;
  localparam int N_BINS = 64;
  localparam int WIDTH  = 16;
  localparam int FRAC   = 15;
  localparam int BIN_AW = $clog2(N_BINS);
  localparam int PW     = 2 * WIDTH;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cplx_t;

  localparam logic signed [PW:0] RND  = {{(PW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [PW:0] SMAX = {{(PW+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW:0] SMIN = {{(PW+2-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};

  // Sum of two products cannot overflow PW+1 bits, so the rounding add is safe here.
  function automatic logic signed [WIDTH-1:0] sat_round(input logic signed [PW:0] x);
    logic signed [PW:0] r;
    r = (x + RND) >>> FRAC;
    if (r > SMAX) begin
      sat_round = SMAX[WIDTH-1:0];
    end else if (r < SMIN) begin
      sat_round = SMIN[WIDTH-1:0];
    end else begin
      sat_round = r[WIDTH-1:0];
    end
  endfunction
endpackage

// File: rtl/ir_bin_multiplier_cplx_mul_pipe.sv
// Two-stage complex multiply / round / saturate datapath, advancing only when en_i is high.
// IR_BIN_BYPASS_EN adds a per-bin bypass that forwards operand a unchanged.
module cplx_mul_pipe
  import ir_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en_i,
  input  cplx_t a_i,
  input  cplx_t b_i,
`ifdef IR_BIN_BYPASS_EN
  input  logic  byp_i,
`endif
  output cplx_t y_o
);
  logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;
  logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;
  logic signed [PW:0]   re_sum, im_sum;
  cplx_t                a_q, y_d;
`ifdef IR_BIN_BYPASS_EN
  logic                 byp_q;
`endif

  assign rr_d   = PW'(a_i.re) * PW'(b_i.re);
  assign ii_d   = PW'(a_i.im) * PW'(b_i.im);
  assign ri_d   = PW'(a_i.re) * PW'(b_i.im);
  assign ir_d   = PW'(a_i.im) * PW'(b_i.re);
  assign re_sum = (PW+1)'(rr_q) - (PW+1)'(ii_q);
  assign im_sum = (PW+1)'(ri_q) + (PW+1)'(ir_q);

  always_comb begin
    y_d.re = sat_round(re_sum);
    y_d.im = sat_round(im_sum);
`ifdef IR_BIN_BYPASS_EN
    if (byp_q) begin
      y_d = a_q;
    end else begin
      y_d.re = sat_round(re_sum);
      y_d.im = sat_round(im_sum);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= '0;
      ii_q  <= '0;
      ri_q  <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      y_o   <= '0;
`ifdef IR_BIN_BYPASS_EN
      byp_q <= 1'b0;
`endif
    end else if (en_i) begin
      rr_q  <= rr_d;
      ii_q  <= ii_d;
      ri_q  <= ri_d;
      ir_q  <= ir_d;
      a_q   <= a_i;
      y_o   <= y_d;
`ifdef IR_BIN_BYPASS_EN
      byp_q <= byp_i;
`endif
    end
  end
endmodule

// File: rtl/ir_bin_multiplier.sv
// Frequency-domain IR stage: addresses the weight ROM per bin and streams bin x weight.
// Optional per-bin bypass port is enabled with IR_BIN_BYPASS_EN.
module ir_bin_multiplier
  import ir_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  i_re,
  input  logic [WIDTH-1:0]  i_im,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic [BIN_AW-1:0] o_w_addr,
  input  logic [WIDTH-1:0]  i_w_re,
  input  logic [WIDTH-1:0]  i_w_im,
`ifdef IR_BIN_BYPASS_EN
  input  logic              i_bypass,
`endif
  output logic [WIDTH-1:0]  o_re,
  output logic [WIDTH-1:0]  o_im,
  output logic              o_valid,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_frame_err
);
  localparam logic [BIN_AW-1:0] CNT_MAX = BIN_AW'(N_BINS - 1);

  logic              adv, acc;
  logic [BIN_AW-1:0] cnt_q, cnt_d;
  logic              s1_valid_q, s1_last_q, s2_valid_q, s2_last_q, out_valid_q, out_last_q;
  cplx_t             s1_a_q, s1_b_q, y;
`ifdef IR_BIN_BYPASS_EN
  logic              s1_byp_q;
`endif

  // A full output register only blocks the whole pipe while downstream is not taking it.
  assign adv         = !out_valid_q || i_ready;
  assign acc         = i_valid && adv;
  assign o_ready     = adv;
  assign o_w_addr    = cnt_q;
  assign o_frame_err = acc && (i_last != (cnt_q == CNT_MAX));
  assign o_re        = y.re;
  assign o_im        = y.im;
  assign o_valid     = out_valid_q;
  assign o_last      = out_last_q;

  always_comb begin
    cnt_d = cnt_q;
    if (acc) begin
      if (i_last || (cnt_q == CNT_MAX)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + BIN_AW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Valid/last tags and S1 operands all move together on the global advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef IR_BIN_BYPASS_EN
      s1_byp_q    <= 1'b0;
`endif
    end else if (adv) begin
      s1_valid_q  <= i_valid;
      s1_last_q   <= i_last;
      s1_a_q      <= cplx_t'({i_re, i_im});
      s1_b_q      <= cplx_t'({i_w_re, i_w_im});
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      out_valid_q <= s2_valid_q;
      out_last_q  <= s2_last_q;
`ifdef IR_BIN_BYPASS_EN
      s1_byp_q    <= i_bypass;
`endif
    end
  end

  cplx_mul_pipe u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (adv),
    .a_i   (s1_a_q),
    .b_i   (s1_b_q),
`ifdef IR_BIN_BYPASS_EN
    .byp_i (s1_byp_q),
`endif
    .y_o   (y)
  );
endmodule
